// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: multicycle processor control FSM.
// Decodes the opcode field of the instruction register and sequences
// datapath control through fetch, decode, execute, memory and writeback.
// Handles memory wait states (MemReady), an illegal-opcode trap and HALT.
module multicycle_control_v2 #(
    parameter int INST_W  = 16,
    parameter int OP_LSB  = 0,
    parameter int OP_W    = 4,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [INST_W-1:0] inst,
    input  logic              MemReady,
    output logic              PCWriteCond,
    output logic              PCWrite,
    output logic              IorD,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              MemRead,
    output logic              IRWrite,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              ALUOp,
    output logic [1:0]        MemToReg,
    output logic [1:0]        PCSrc,
    output logic              Illegal,
    output logic              Halted,
    output logic [4:0]        State
);

    typedef enum logic [4:0] {
        ST_FETCH     = 5'd0,
        ST_DECODE    = 5'd1,
        ST_R_ADD     = 5'd2,
        ST_R_SUB     = 5'd3,
        ST_R_WB      = 5'd4,
        ST_J_EXE     = 5'd5,
        ST_J_WB      = 5'd6,
        ST_M_ADDR    = 5'd7,
        ST_M_LW_RD   = 5'd8,
        ST_M_LW_WB   = 5'd9,
        ST_M_ADDI_WB = 5'd10,
        ST_M_SW      = 5'd11,
        ST_B_CMP     = 5'd12,
        ST_B_TGT     = 5'd13,
        ST_B_TAKE    = 5'd14,
        ST_I_IMM     = 5'd15,
        ST_I_WB      = 5'd16,
        ST_TRAP      = 5'd17,
        ST_HALT      = 5'd18
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_illegal_next;
    logic [OP_W-1:0] w_op;
    logic            w_op_wide;
    logic [3:0]      r_op_q;
    logic            w_unused_inst;

    assign w_op           = inst[OP_LSB+OP_W-1:OP_LSB];
    assign w_illegal_next = TRAP_EN ? ST_TRAP : ST_FETCH;
    assign w_unused_inst  = ^inst;
    assign State          = r_state;

    // Any opcode bit above bit 3 set means the opcode is > 15 and illegal.
    if (OP_W > 4) begin : g_wide_op
        assign w_op_wide = |w_op[OP_W-1:4];
    end else begin : g_narrow_op
        assign w_op_wide = 1'b0;
    end

    // State register with asynchronous abort to FETCH.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_FETCH;
        else          r_state <= w_next;
    end

    // Opcode latched leaving DECODE; only legal (<=15) opcodes reach states
    // that consult it, so the low four bits are all that need keeping.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)                   r_op_q <= '0;
        else if (r_state == ST_DECODE)  r_op_q <= w_op[3:0];
    end

    // Next-state selection and per-state control outputs.
    always_comb begin
        w_next      = ST_FETCH;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ALUOp       = 1'b0;
        MemToReg    = 2'd0;
        PCSrc       = 2'd0;
        Illegal     = 1'b0;
        Halted      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                // Gated with Reset_n so no write enable leaks out while reset is held.
                if (MemReady && Reset_n) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                w_next = MemReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                if (w_op_wide) begin
                    w_next = w_illegal_next;
                end else begin
                    case (w_op[3:0])
                        4'd0:                w_next = ST_R_ADD;
                        4'd1, 4'd2, 4'd3:    w_next = ST_R_SUB;
                        4'd4, 4'd6:          w_next = ST_J_EXE;
                        4'd5, 4'd15:         w_next = ST_I_IMM;
                        4'd8, 4'd9, 4'd10:   w_next = ST_M_ADDR;
                        4'd11:               w_next = ST_B_CMP;
                        4'd14:               w_next = ST_HALT;
                        default:             w_next = w_illegal_next;
                    endcase
                end
            end
            ST_R_ADD: begin
                ALUSrcA = 2'd1;
                w_next  = ST_R_WB;
            end
            ST_R_SUB: begin
                ALUSrcA = 2'd1;
                ALUOp   = 1'b1;
                w_next  = ST_R_WB;
            end
            ST_R_WB: begin
                RegWrite = 1'b1;
                if (r_op_q == 4'd1)      MemToReg = 2'd3;
                else if (r_op_q == 4'd3) MemToReg = 2'd2;
                w_next = ST_FETCH;
            end
            ST_J_EXE: begin
                ALUSrcA = 2'd1;
                if (r_op_q == 4'd6) ALUSrcB = 2'd2;
                w_next = ST_J_WB;
            end
            ST_J_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = 2'd1;
                w_next   = ST_FETCH;
            end
            ST_M_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                case (r_op_q)
                    4'd8:    w_next = ST_M_ADDI_WB;
                    4'd9:    w_next = ST_M_LW_RD;
                    4'd10:   w_next = ST_M_SW;
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_M_LW_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                w_next  = MemReady ? ST_M_LW_WB : ST_M_LW_RD;
            end
            ST_M_LW_WB: begin
                RegWrite = 1'b1;
                MemToReg = 2'd1;
                w_next   = ST_FETCH;
            end
            ST_M_ADDI_WB: begin
                RegWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_M_SW: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = MemReady ? ST_FETCH : ST_M_SW;
            end
            ST_B_CMP: begin
                ALUSrcA = 2'd1;
                ALUOp   = 1'b1;
                w_next  = ST_B_TGT;
            end
            ST_B_TGT: begin
                ALUSrcB = 2'd2;
                w_next  = ST_B_TAKE;
            end
            ST_B_TAKE: begin
                PCWriteCond = 1'b1;
                PCSrc       = 2'd1;
                w_next      = ST_FETCH;
            end
            ST_I_IMM: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
                w_next  = ST_I_WB;
            end
            ST_I_WB: begin
                RegWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_TRAP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'd2;
                Illegal = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_HALT: begin
                Halted = 1'b1;
                w_next = ST_HALT;
            end
            default: w_next = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Self-checking bench for multicycle_control_v2: vector table, directed
// corner-case sequences and randomized instruction streams against a model.
module tb_multicycle_control_v2;

    typedef struct packed {
        logic       pcwc, pcw, iord, regw, memw, memr, irw;
        logic [1:0] asa, asb;
        logic       aluop;
        logic [1:0] m2r, pcsrc;
        logic       ill, halt;
    } ctl_t;

    typedef struct {
        logic [15:0]      iv;
        int               len;
        logic [0:5][4:0]  path;
    } vec_t;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [15:0] inst;
    logic        MemReady;

    logic PCWriteCond, PCWrite, IorD, RegWrite, MemWrite, MemRead, IRWrite, ALUOp, Illegal, Halted;
    logic [1:0] ALUSrcA, ALUSrcB, MemToReg, PCSrc;
    logic [4:0] State;

    logic PCWriteCond_2, PCWrite_2, IorD_2, RegWrite_2, MemWrite_2, MemRead_2, IRWrite_2, ALUOp_2, Illegal_2, Halted_2;
    logic [1:0] ALUSrcA_2, ALUSrcB_2, MemToReg_2, PCSrc_2;
    logic [4:0] State_2;

    ctl_t act;
    assign act = {PCWriteCond, PCWrite, IorD, RegWrite, MemWrite, MemRead, IRWrite,
                  ALUSrcA, ALUSrcB, ALUOp, MemToReg, PCSrc, Illegal, Halted};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int path_q[$];
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    multicycle_control_v2 #(.INST_W(16), .OP_LSB(0), .OP_W(4), .TRAP_EN(1'b1)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .inst(inst), .MemReady(MemReady),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemToReg(MemToReg), .PCSrc(PCSrc),
        .Illegal(Illegal), .Halted(Halted), .State(State)
    );

    multicycle_control_v2 #(.INST_W(16), .OP_LSB(0), .OP_W(4), .TRAP_EN(1'b0)) dut_notrap (
        .CLK(CLK), .Reset_n(Reset_n), .inst(inst), .MemReady(MemReady),
        .PCWriteCond(PCWriteCond_2), .PCWrite(PCWrite_2), .IorD(IorD_2), .RegWrite(RegWrite_2),
        .MemWrite(MemWrite_2), .MemRead(MemRead_2), .IRWrite(IRWrite_2), .ALUSrcA(ALUSrcA_2),
        .ALUSrcB(ALUSrcB_2), .ALUOp(ALUOp_2), .MemToReg(MemToReg_2), .PCSrc(PCSrc_2),
        .Illegal(Illegal_2), .Halted(Halted_2), .State(State_2)
    );

    // Expected control word for a given state, instruction opcode and inputs.
    function automatic ctl_t exp_ctl(input int s, input int op, input bit ready, input bit rstn);
        ctl_t c;
        c = '0;
        case (s)
            0:  begin c.memr = 1; c.asb = 2'd1; c.irw = ready & rstn; c.pcw = ready & rstn; end
            2:  c.asa = 2'd1;
            3:  begin c.asa = 2'd1; c.aluop = 1; end
            4:  begin c.regw = 1; c.m2r = (op == 1) ? 2'd3 : (op == 3) ? 2'd2 : 2'd0; end
            5:  begin c.asa = 2'd1; if (op == 6) c.asb = 2'd2; end
            6:  begin c.regw = 1; c.pcw = 1; c.pcsrc = 2'd1; end
            7:  begin c.asa = 2'd1; c.asb = 2'd2; end
            8:  begin c.iord = 1; c.memr = 1; end
            9:  begin c.regw = 1; c.m2r = 2'd1; end
            10: c.regw = 1;
            11: begin c.iord = 1; c.memw = 1; end
            12: begin c.asa = 2'd1; c.aluop = 1; end
            13: c.asb = 2'd2;
            14: begin c.pcwc = 1; c.pcsrc = 2'd1; end
            15: begin c.asa = 2'd2; c.asb = 2'd2; end
            16: c.regw = 1;
            17: begin c.pcw = 1; c.pcsrc = 2'd2; c.ill = 1; end
            18: c.halt = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instruction-class state path (TRAP_EN=1), derived from the opcode map.
    function automatic void build_path(input int op);
        case (op)
            0:         path_q = '{0, 1, 2, 4};
            1, 2, 3:   path_q = '{0, 1, 3, 4};
            4, 6:      path_q = '{0, 1, 5, 6};
            5, 15:     path_q = '{0, 1, 15, 16};
            8:         path_q = '{0, 1, 7, 10};
            9:         path_q = '{0, 1, 7, 8, 9};
            10:        path_q = '{0, 1, 7, 11};
            11:        path_q = '{0, 1, 12, 13, 14};
            14:        path_q = '{0, 1, 18};
            default:   path_q = '{0, 1, 17};
        endcase
    endfunction

    function automatic vec_t mk(input logic [15:0] iv, input int len,
                                input logic [4:0] a, b, c, d, e);
        vec_t r;
        r.iv = iv;
        r.len = len;
        r.path = {a, b, c, d, e, 5'd0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One clock: apply MemReady, compare at the falling edge, advance to posedge+1.
    task automatic step(input int s, input int op, input bit ready, input string tag);
        MemReady = ready;
        @(negedge CLK);
        chk($sformatf("%s_state", tag), {27'd0, State}, s);
        chk($sformatf("%s_ctl_s%0d", tag, s), 32'(act), 32'(exp_ctl(s, op, ready, 1'b1)));
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Full instruction: w0 not-ready cycles in FETCH, w1 in the memory wait state;
    // inst is replaced by 'post' once DECODE has passed.
    task automatic run_instr(input int op, input logic [15:0] iv, input int w0, input int w1,
                             input logic [15:0] post, input string tag);
        int p[$];
        build_path(op);
        p = path_q;
        inst = iv;
        cyc = 0;
        foreach (p[i]) begin
            int waits;
            waits = (p[i] == 0) ? w0 : (p[i] == 8 || p[i] == 11) ? w1 : 0;
            for (int k = 0; k < waits; k++) step(p[i], op, 1'b0, tag);
            if (waits == 0 && p[i] != 0 && p[i] != 8 && p[i] != 11)
                step(p[i], op, 1'($urandom_range(0, 1)), tag);
            else
                step(p[i], op, 1'b1, tag);
            if (p[i] == 1) inst = post;
        end
    endtask

    // Assert reset between clock edges and check the asynchronous effect.
    task automatic mid_reset(input string tag);
        MemReady = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        chk($sformatf("%s_state", tag), {27'd0, State}, 0);
        chk($sformatf("%s_ctl", tag), 32'(act), 32'(exp_ctl(0, 0, 1'b1, 1'b0)));
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        int op;
        int e1[4], e2[4], il1[4];
        logic [15:0] iv;

        vecs.push_back(mk(16'h0000, 4, 0, 1, 2, 4, 0));
        vecs.push_back(mk(16'hA5F1, 4, 0, 1, 3, 4, 0));
        vecs.push_back(mk(16'h0002, 4, 0, 1, 3, 4, 0));
        vecs.push_back(mk(16'h1233, 4, 0, 1, 3, 4, 0));
        vecs.push_back(mk(16'h0004, 4, 0, 1, 5, 6, 0));
        vecs.push_back(mk(16'hFFF6, 4, 0, 1, 5, 6, 0));
        vecs.push_back(mk(16'h0005, 4, 0, 1, 15, 16, 0));
        vecs.push_back(mk(16'h800F, 4, 0, 1, 15, 16, 0));
        vecs.push_back(mk(16'h0008, 4, 0, 1, 7, 10, 0));
        vecs.push_back(mk(16'h4449, 5, 0, 1, 7, 8, 9));
        vecs.push_back(mk(16'h000A, 4, 0, 1, 7, 11, 0));
        vecs.push_back(mk(16'h000B, 5, 0, 1, 12, 13, 14));
        vecs.push_back(mk(16'h0007, 3, 0, 1, 17, 0, 0));
        vecs.push_back(mk(16'hBEEC, 3, 0, 1, 17, 0, 0));
        vecs.push_back(mk(16'h000D, 3, 0, 1, 17, 0, 0));

        Reset_n  = 1'b0;
        MemReady = 1'b1;
        inst     = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset_state", {27'd0, State}, 0);
        chk("reset_ctl", 32'(act), 32'(exp_ctl(0, 0, 1'b1, 1'b0)));
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;

        // Vector table: zero-wait paths and latencies.
        foreach (vecs[i]) begin
            inst = vecs[i].iv;
            for (int j = 0; j < vecs[i].len; j++)
                step(int'(vecs[i].path[j]), int'(vecs[i].iv[3:0]), 1'b1, $sformatf("vec%0d", i));
        end

        // Reset mid-instruction (R_ADD), then resume with a clean add.
        inst = 16'h0000;
        step(0, 0, 1'b1, "pre_rst");
        step(1, 0, 1'b1, "pre_rst");
        step(2, 0, 1'b1, "pre_rst");
        mid_reset("rst_radd");
        run_instr(0, 16'h0000, 0, 0, 16'h0000, "post_rst");

        // Reset during a load wait.
        inst = 16'h0009;
        step(0, 9, 1'b1, "lw_pre");
        step(1, 9, 1'b1, "lw_pre");
        step(7, 9, 1'b1, "lw_pre");
        step(8, 9, 1'b0, "lw_pre");
        mid_reset("rst_lwwait");

        // Load with two FETCH waits and three read waits: 10 cycles.
        run_instr(9, 16'h0009, 2, 3, 16'h0009, "lw_wait");
        chk("lw_latency", cyc, 10);

        // Store with waits.
        run_instr(10, 16'h000A, 1, 2, 16'h0000, "sw_wait");
        chk("sw_latency", cyc, 7);

        // Illegal opcode: trapping and non-trapping instances side by side.
        mid_reset("sync");
        e1  = '{0, 1, 17, 0};
        e2  = '{0, 1, 0, 1};
        il1 = '{0, 0, 1, 0};
        inst = 16'h0007;
        for (int i = 0; i < 4; i++) begin
            MemReady = 1'b1;
            @(negedge CLK);
            chk($sformatf("trap_state%0d", i), {27'd0, State}, e1[i]);
            chk($sformatf("trap_ill%0d", i), {31'd0, Illegal}, il1[i]);
            chk($sformatf("trap_ctl%0d", i), 32'(act), 32'(exp_ctl(e1[i], 7, 1'b1, 1'b1)));
            chk($sformatf("notrap_state%0d", i), {27'd0, State_2}, e2[i]);
            chk($sformatf("notrap_ill%0d", i), {31'd0, Illegal_2}, 0);
            @(posedge CLK);
            #1;
        end
        mid_reset("sync2");

        // Branch: inst changes to 0x0008 while in B_CMP; path must hold.
        run_instr(11, 16'h000B, 0, 0, 16'h0008, "bne_chg");
        chk("bne_latency", cyc, 5);

        // Randomized instruction stream with random wait states.
        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 15));
            if (op == 14) op = 0;
            iv = 16'($urandom());
            iv[3:0] = 4'(op);
            run_instr(op, iv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      16'($urandom()), $sformatf("rnd%0d_op%0d", n, op));
        end

        // HALT: stays put, MemRead low, until reset.
        inst = 16'h000E;
        step(0, 14, 1'b1, "halt");
        step(1, 14, 1'b1, "halt");
        for (int i = 0; i < 20; i++) step(18, 14, 1'($urandom_range(0, 1)), "halt");
        mid_reset("rst_halt");
        inst = 16'h0000;
        MemReady = 1'b1;
        @(negedge CLK);
        chk("after_halt_halted", {31'd0, Halted}, 0);
        chk("after_halt_state", {27'd0, State}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_v2.md
Name: multicycle_control_v2

Overview:
Parametrised successor to the processor's multicycle control FSM. Decodes the opcode field of the instruction register and sequences datapath control through fetch, decode, execute, memory and writeback. Adds four things:
- memory wait-state handshake (MemReady);
- opcode latched at decode;
- an illegal-opcode trap and a HALT state;
- RegWrite asserted in every register writeback state.
Sits between the IR/memory interface and the datapath muxes/ALU.

Parameters:
INST_W, 16, instruction register width.
OP_LSB, 0, bit position of opcode LSB within inst.
OP_W, 4, opcode field width (>=4); opcodes >15 are illegal.
TRAP_EN, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode returns to FETCH silently.

Ports:
CLK  input  1  rising-edge clock.
Reset_n  input  1  asynchronous active-low reset.
inst  input  INST_W  instruction register contents.
MemReady  input  1  memory has completed the current read/write this cycle.
PCWriteCond, PCWrite, IorD, RegWrite, MemWrite, MemRead, IRWrite  output  1 each  datapath enables/selects.
ALUSrcA  output  2  0=PC, 1=A, 2=zero.
ALUSrcB  output  2  0=B, 1=const 2, 2=imm.
ALUOp  output  1  0=add, 1=sub.
MemToReg  output  2  0=ALUOut, 1=MDR, 2=zero flag, 3=pos flag.
PCSrc  output  2  0=ALU, 1=ALUOut, 2=trap vector.
Illegal  output  1  one-cycle pulse in TRAP.
Halted  output  1  high while in HALT.
State  output  5  current state encoding (debug).

Behaviour:
- Reset (Reset_n low, async): state = FETCH. All outputs are combinational from state, so during reset they take FETCH values: MemRead=1, ALUSrcB=1, all else 0. Registered op_q clears to 0.
- Defaults each state: all controls 0. Listed signals override.
- Decode: op = inst[OP_LSB+OP_W-1:OP_LSB] is registered into op_q on the DECODE->next edge. All post-decode branching uses op_q, never live inst.
- Encodings and per-state controls:
  - FETCH (0): MemRead=1, ALUSrcB=1. If MemReady: IRWrite=1, PCWrite=1, go to DECODE. Else stay, with IRWrite=PCWrite=0 (Mealy on MemReady).
  - DECODE (1): no controls. Next by op:
    - 0 -> R_ADD
    - 1,2,3 -> R_SUB
    - 4,6 -> J_EXE
    - 5,15 -> I_IMM
    - 8,9,10 -> M_ADDR
    - 11 -> B_CMP
    - 14 -> HALT
    - else -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
  - R_ADD (2): ALUSrcA=1 -> R_WB.
  - R_SUB (3): ALUSrcA=1, ALUOp=1 -> R_WB.
  - R_WB (4): RegWrite=1; MemToReg = 3 if op_q=1, 2 if op_q=3, else 0 -> FETCH.
  - J_EXE (5): ALUSrcA=1. If op_q=6, also ALUSrcB=2 -> J_WB.
  - J_WB (6): RegWrite=1, PCWrite=1, PCSrc=1 -> FETCH.
  - M_ADDR (7): ALUSrcA=1, ALUSrcB=2. Next: op_q=8 -> M_ADDI_WB, 9 -> M_LW_RD, 10 -> M_SW.
  - M_LW_RD (8): IorD=1, MemRead=1. Stay until MemReady, then -> M_LW_WB.
  - M_LW_WB (9): RegWrite=1, MemToReg=1 -> FETCH.
  - M_ADDI_WB (10): RegWrite=1 -> FETCH.
  - M_SW (11): IorD=1, MemWrite=1. Stay until MemReady, then -> FETCH.
  - B_CMP (12): ALUSrcA=1, ALUOp=1 -> B_TGT.
  - B_TGT (13): ALUSrcB=2 -> B_TAKE.
  - B_TAKE (14): PCWriteCond=1, PCSrc=1 -> FETCH.
  - I_IMM (15): ALUSrcA=2, ALUSrcB=2 -> I_WB.
  - I_WB (16): RegWrite=1 -> FETCH.
  - TRAP (17): PCWrite=1, PCSrc=2, Illegal=1 -> FETCH.
  - HALT (18): Halted=1. Remains until reset.
  - Unused encodings: all controls 0 -> FETCH.
- Wait states: MemRead/MemWrite/IorD are held constant for every wait cycle. There is no timeout.
- Changes on inst after DECODE do not affect sequencing.
- Reset mid-instruction, including during a wait: abort immediately to FETCH. No partial writeback enables are asserted after reset assertion.
- Zero-wait latencies (cycles): R-type 4, addi 4, lw 5, sw 4, jal/jalr 4, lui/lli 4, bne 5, trap 3.
- No simulation-only display output in RTL.

Test Plan:
1. Reset_n low mid-sim -> State=0, MemRead=1, IRWrite=0, Illegal=0 asynchronously. Release, MemReady=1 -> State sequence 0,1.
2. inst=0x0000 (add), MemReady=1 -> States 0,1,2,4,0. RegWrite=1 only in state 4, MemToReg=0. Repeat with op 1: MemToReg=3. Repeat with op 3: MemToReg=2.
3. lw (op 9), MemReady low 2 cycles in FETCH and 3 in M_LW_RD -> FETCH held 3 cycles with PCWrite=0 until the ready cycle; M_LW_RD held 4 cycles with IorD=1, MemRead=1. Total 10 cycles; M_LW_WB RegWrite=1, MemToReg=1.
4. Opcode 7 with TRAP_EN=1 -> 0,1,17,0; Illegal high exactly 1 cycle, PCSrc=2, PCWrite=1. With TRAP_EN=0 -> 0,1,0, Illegal never high.
5. bne (op 11), inst changed to 0x0008 during B_CMP -> sequence 12,13,14 still taken; PCWriteCond=1 only in 14.
6. Opcode 14 -> State=18, Halted=1 for 20 cycles with MemRead=0. Reset_n pulse -> FETCH, Halted=0.
